// File: rtl/difftest_sim_top_pkg.sv
// Shared types and constants for the difftest simulation top.
// Banner text, UART FSM encoding and the "no data" UART sentinel live here.
package difftest_sim_top_pkg;

    localparam int unsigned STEP_WIDTH_DEF = 8;

    localparam int unsigned BANNER_LEN = 6;
    // Element 0 is the first character sent.
    localparam logic [BANNER_LEN-1:0][7:0] BANNER = {8'h0A, "O", "L", "L", "E", "H"};

    localparam logic [7:0] UART_NO_DATA = 8'hFF;

    typedef enum logic [0:0] {
        UART_BANNER = 1'b0,
        UART_POLL   = 1'b1
    } uart_state_e;

endpackage

// File: rtl/sim_top_commit_gen.sv
// Pseudo-random commit generator: 16-bit Fibonacci LFSR, low two bits clamped to COMMIT_MAX.
// Latency 1 cycle from LFSR state to o_step; free-running, no backpressure.
module sim_top_commit_gen #(
    parameter int unsigned STEP_WIDTH = 8,
    parameter int unsigned COMMIT_MAX = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [STEP_WIDTH-1:0] o_step
);

    localparam logic [STEP_WIDTH-1:0] STEP_MAX = STEP_WIDTH'(COMMIT_MAX);

    logic [15:0]           r_lfsr;
    logic [STEP_WIDTH-1:0] r_step;
    logic                  w_fb;
    logic [STEP_WIDTH-1:0] w_raw;
    logic [STEP_WIDTH-1:0] w_clamped;

    // Taps 16,14,13,11 in 1-based numbering.
    assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_raw     = STEP_WIDTH'(r_lfsr[1:0]);
    assign w_clamped = (w_raw > STEP_MAX) ? STEP_MAX : w_raw;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
            r_step <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            r_step <= w_clamped;
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/difftest_sim_top.sv
// Difftest simulation top: commit stream, UART banner/echo, perf and log bookkeeping.
// Latency: difftest_step 1 cycle from LFSR, UART echo 1 cycle after the read strobe.
// No backpressure; the harness must accept every strobe. Option macro: SIM_TOP_GFIFO_EN.
module difftest_sim_top
    import difftest_sim_top_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = STEP_WIDTH_DEF,
    parameter int unsigned COMMIT_MAX = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned UART_GAP   = 4,
    parameter logic [63:0] FAIL_AT    = 64'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [63:0]           io_logCtrl_log_begin,
    input  logic [63:0]           io_logCtrl_log_end,
    input  logic [63:0]           io_logCtrl_log_level,
    input  logic                  io_perfInfo_clean,
    input  logic                  io_perfInfo_dump,
    output logic                  io_uart_out_valid,
    output logic [7:0]            io_uart_out_ch,
    output logic                  io_uart_in_valid,
    input  logic [7:0]            io_uart_in_ch,
`ifdef SIM_TOP_GFIFO_EN
    output logic                  simv_result,
`endif
    output logic [STEP_WIDTH-1:0] difftest_step
);

    localparam int unsigned GAP_W = (UART_GAP > 1) ? $clog2(UART_GAP) : 1;

    logic [STEP_WIDTH-1:0] w_step;
    logic [63:0]           w_step_ext;
    logic [63:0]           w_total_next;
    logic                  w_log_hit;
    logic                  w_gap_hit;

    logic [63:0]           r_cycle;
    logic [63:0]           r_total_commits;
    logic [63:0]           r_perf_dump;
    logic [31:0]           r_log_lines;

    uart_state_e           r_state;
    logic [2:0]            r_idx;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_out_vld;
    logic [7:0]            r_out_ch;
    logic                  r_in_vld;

    sim_top_commit_gen #(
        .STEP_WIDTH (STEP_WIDTH),
        .COMMIT_MAX (COMMIT_MAX),
        .LFSR_SEED  (LFSR_SEED)
    ) u_commit_gen (
        .clock  (clock),
        .reset  (reset),
        .o_step (w_step)
    );

    assign difftest_step = w_step;
    assign w_step_ext    = 64'(w_step);
    assign w_total_next  = io_perfInfo_clean ? 64'd0 : (r_total_commits + w_step_ext);
    assign w_log_hit     = (io_logCtrl_log_level != 64'd0)
                        && (r_cycle >= io_logCtrl_log_begin)
                        && (r_cycle <  io_logCtrl_log_end)
                        && (w_step != '0);

    // The harness prints from r_perf_dump / r_log_lines; the snapshot includes this cycle's commits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle         <= 64'd0;
            r_total_commits <= 64'd0;
            r_perf_dump     <= 64'd0;
            r_log_lines     <= 32'd0;
        end else begin
            r_cycle         <= r_cycle + 64'd1;
            r_total_commits <= w_total_next;
            if (io_perfInfo_dump) begin
                r_perf_dump <= w_total_next;
            end
            if (w_log_hit) begin
                r_log_lines <= r_log_lines + 32'd1;
            end
        end
    end

    logic w_unused_bookkeeping;
    assign w_unused_bookkeeping = ^{r_perf_dump, r_log_lines, FAIL_AT};

`ifdef SIM_TOP_GFIFO_EN
    logic [63:0] r_fault_total;
    logic        r_simv_result;

    // Separate from the perf counter so a perf clean cannot mask an injected failure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fault_total <= 64'd0;
            r_simv_result <= 1'b0;
        end else begin
            r_fault_total <= r_fault_total + w_step_ext;
            if ((FAIL_AT != 64'd0) && (r_fault_total >= FAIL_AT)) begin
                r_simv_result <= 1'b1;
            end
        end
    end

    assign simv_result = r_simv_result;
`endif

    assign w_gap_hit = (r_gap == GAP_W'(UART_GAP - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= UART_BANNER;
            r_idx     <= 3'd0;
            r_gap     <= '0;
            r_out_vld <= 1'b0;
            r_out_ch  <= 8'd0;
            r_in_vld  <= 1'b0;
        end else begin
            r_out_vld <= 1'b0;
            r_in_vld  <= 1'b0;
            r_gap     <= w_gap_hit ? '0 : (r_gap + GAP_W'(1));
            if (r_in_vld && (io_uart_in_ch != UART_NO_DATA)) begin
                r_out_vld <= 1'b1;
                r_out_ch  <= io_uart_in_ch;
            end
            case (r_state)
                UART_BANNER: begin
                    if (w_gap_hit) begin
                        r_out_vld <= 1'b1;
                        r_out_ch  <= BANNER[r_idx];
                        if (r_idx == 3'(BANNER_LEN - 1)) begin
                            r_idx   <= 3'd0;
                            r_state <= UART_POLL;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                UART_POLL: begin
                    if (w_gap_hit) begin
                        r_in_vld <= 1'b1;
                    end
                end
                default: r_state <= UART_BANNER;
            endcase
        end
    end

    assign io_uart_out_valid = r_out_vld;
    assign io_uart_out_ch    = r_out_ch;
    assign io_uart_in_valid  = r_in_vld;

endmodule

// File: tb/tb_difftest_sim_top.sv
// Directed bench for difftest_sim_top: LFSR step model, UART banner/echo, perf dump, log window.
module tb_difftest_sim_top;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          CMAX    = 2;
    localparam int          FAILLIM = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] log_begin, log_end, log_level;
    logic        perf_clean, perf_dump;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;
    logic        uart_in_valid;
    logic [7:0]  uart_in_ch;
    logic [7:0]  step;
`ifdef SIM_TOP_GFIFO_EN
    logic        simv_result;
`endif

    difftest_sim_top #(
        .STEP_WIDTH (8),
        .COMMIT_MAX (CMAX),
        .LFSR_SEED  (SEED),
        .UART_GAP   (4),
        .FAIL_AT    (64'(FAILLIM))
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .io_logCtrl_log_begin (log_begin),
        .io_logCtrl_log_end   (log_end),
        .io_logCtrl_log_level (log_level),
        .io_perfInfo_clean    (perf_clean),
        .io_perfInfo_dump     (perf_dump),
        .io_uart_out_valid    (uart_out_valid),
        .io_uart_out_ch       (uart_out_ch),
        .io_uart_in_valid     (uart_in_valid),
        .io_uart_in_ch        (uart_in_ch),
`ifdef SIM_TOP_GFIFO_EN
        .simv_result          (simv_result),
`endif
        .difftest_step        (step)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] m_cycle;
    logic [7:0]  exp_step;
    logic [15:0] m_lfsr;
    logic [63:0] m_total;
    logic [63:0] m_fault;
    bit          m_simv;
    int          m_log;
    int          echo_at;
    logic [63:0] psum;
    logic [7:0]  banner_tab [6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] clamp2(input logic [1:0] v);
        return (int'(v) > CMAX) ? 8'(CMAX) : 8'(v);
    endfunction

    task automatic model_reset();
        m_cycle  = 64'd0;
        exp_step = 8'd0;
        m_lfsr   = SEED;
        m_total  = 64'd0;
        m_fault  = 64'd0;
        m_simv   = 1'b0;
        m_log    = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_step"},    64'(step), 64'd0);
        chk({tag, "_out_vld"}, 64'(uart_out_valid), 64'd0);
        chk({tag, "_out_ch"},  64'(uart_out_ch), 64'd0);
        chk({tag, "_in_vld"},  64'(uart_in_valid), 64'd0);
`ifdef SIM_TOP_GFIFO_EN
        chk({tag, "_simv"},    64'(simv_result), 64'd0);
`endif
    endtask

    // Advance one clock and check every observable against the model.
    task automatic tick();
        logic [7:0] s_prev;
        bit         clean_prev;
        bit         log_prev;
        bit         e_vld;
        bit         e_in;
        logic [7:0] e_ch;
        int         c;
        s_prev     = exp_step;
        clean_prev = perf_clean;
        log_prev   = (log_level != 64'd0) && (m_cycle >= log_begin) && (m_cycle < log_end) && (exp_step != 8'd0);
        if (log_prev) $display("log: cycle %0d commits %0d", m_cycle, exp_step);
        @(posedge clock);
        #1;
        if (m_fault >= 64'(FAILLIM)) m_simv = 1'b1;
        m_fault  = m_fault + 64'(s_prev);
        m_total  = clean_prev ? 64'd0 : (m_total + 64'(s_prev));
        if (log_prev) m_log++;
        m_cycle  = m_cycle + 64'd1;
        exp_step = clamp2(m_lfsr[1:0]);
        m_lfsr   = lfsr_next(m_lfsr);
        c        = int'(m_cycle);
        e_vld    = ((c % 4 == 0) && (c >= 4) && (c <= 24)) || (c == echo_at);
        e_in     = (c % 4 == 0) && (c >= 28);
        e_ch     = (c == echo_at) ? 8'h41 : ((c <= 24 && c >= 4) ? banner_tab[c/4 - 1] : 8'h00);
        chk("step", 64'(step), 64'(exp_step));
        chk("uart_out_vld", 64'(uart_out_valid), 64'(e_vld));
        if (e_vld) chk("uart_out_ch", 64'(uart_out_ch), 64'(e_ch));
        chk("uart_in_vld", 64'(uart_in_valid), 64'(e_in));
`ifdef SIM_TOP_GFIFO_EN
        chk("simv_result", 64'(simv_result), 64'(m_simv));
`endif
    endtask

    initial begin
        banner_tab[0] = 8'h48; banner_tab[1] = 8'h45; banner_tab[2] = 8'h4C;
        banner_tab[3] = 8'h4C; banner_tab[4] = 8'h4F; banner_tab[5] = 8'h0A;
        reset      = 1'b0;
        log_level  = 64'd1;
        log_begin  = 64'd10;
        log_end    = 64'd20;
        perf_clean = 1'b0;
        perf_dump  = 1'b0;
        uart_in_ch = 8'hFF;
        echo_at    = 29;
        model_reset();

        repeat (50) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;

        // Banner, then one echoed character and one empty poll.
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_cycle == 64'd28) uart_in_ch = 8'h41;
            if (m_cycle == 64'd29) uart_in_ch = 8'hFF;
        end
        chk("log_window_lines", 64'(dut.r_log_lines), 64'(m_log));

        // Inverted window must not log anything.
        log_begin = 64'd50;
        log_end   = 64'd40;
        while (m_cycle < 64'd60) tick();
        chk("log_inverted_lines", 64'(dut.r_log_lines), 64'(m_log));

        while (m_cycle < 64'd100) tick();
        perf_clean = 1'b1;
        tick();
        perf_clean = 1'b0;
        psum = 64'(exp_step);
        while (m_cycle < 64'd110) begin
            tick();
            psum = psum + 64'(exp_step);
        end
        perf_dump = 1'b1;
        tick();
        perf_dump = 1'b0;
        $display("perf dump: total commits %0d", dut.r_perf_dump);
        chk("perf_dump", dut.r_perf_dump, psum);
        chk("perf_total", dut.r_total_commits, m_total);

        repeat (5) tick();
        // Asynchronous reset mid-run, checked before any clock edge.
        reset = 1'b0;
        #2;
        check_idle_outputs("midreset");
        model_reset();
        echo_at = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
